packet_sequencer: RTL and testbench
===================================

Name: packet_sequencer

Overview:
Downstream consumer of the 16x8 packet memory. On a start pulse it walks the memory from address 0 and decodes each 8-bit packet into a spike or reward event for the neuron array, using a valid/ready handshake. It drives the memory read address. It treats the memory's combinational read data as valid in the same cycle the address is presented.

Parameters:
DEPTH, 16, number of memory entries walked
ADDR_W, 4, memory address width (log2 DEPTH)
DATA_W, 8, packet width
CNT_W, 8, width of the saturating emitted-event counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  1-cycle pulse; begins a run; ignored unless in IDLE
stop  input  1  synchronous abort; any state goes to IDLE next cycle
loop_en  input  1  1 = wrap from DEPTH-1 to address 0 and continue
mem_write_mode  input  1  memory write_mode; while high, no fetch is decoded
mem_addr  output  ADDR_W  memory read address (registered pointer)
mem_packet  input  DATA_W  memory read data for mem_addr
evt_valid  output  1  event available
evt_ready  input  1  consumer accepts the event
evt_neuron  output  2  target neuron index
evt_weight  output  4  signed weight (spike) or unsigned magnitude (reward)
evt_reward  output  1  1 = reward event, 0 = spike event
busy  output  1  high in FETCH or EMIT
done  output  1  1-cycle pulse at end of run
evt_count  output  CNT_W  events accepted in the current run; saturates at 2^CNT_W-1

Behaviour:
- Reset values: mem_addr=0, evt_valid=0, evt_neuron=0, evt_weight=0, evt_reward=0, busy=0, done=0, evt_count=0, state=IDLE.
- Packet format:
  - [7:6] op: 00 NOP, 01 SPIKE, 10 REWARD, 11 END.
  - [5:4] neuron.
  - [3:0] weight.
- States: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 → ptr=0, evt_count=0, go FETCH.
- FETCH (mem_addr=ptr):
  - If mem_write_mode=1: stall in FETCH, nothing decoded.
  - Otherwise decode mem_packet:
    - NOP → advance.
    - SPIKE/REWARD → register neuron, weight and reward (=op[1]), set evt_valid, go EMIT.
    - END → go DONE, regardless of loop_en.
- EMIT:
  - evt_valid and the event fields are held stable until evt_valid & evt_ready.
  - On that handshake: evt_valid=0, evt_count+=1 (saturating), advance.
  - mem_write_mode has no effect in EMIT, because the fields are already registered.
- Advance:
  - ptr<DEPTH-1 → ptr+1, go FETCH.
  - ptr==DEPTH-1 with loop_en=1 → ptr=0, go FETCH.
  - ptr==DEPTH-1 with loop_en=0 → go DONE.
- DONE: done=1 for one cycle, then IDLE. ptr and evt_count are held until the next start.
- Latency: start sampled at edge N → FETCH in cycle N+1 → for a SPIKE at addr 0, evt_valid is high from cycle N+2.
  - Back-to-back events with evt_ready held high: one event every 2 cycles.
  - A NOP costs 1 cycle.
- stop has priority over every other transition:
  - Next state is IDLE, evt_valid=0, no done pulse.
  - evt_count and mem_addr are held.
- start while busy is ignored. start and stop in the same IDLE cycle: stop wins, stay IDLE.
- Asynchronous reset mid-run: immediate return to the reset values; any pending event is dropped.
- evt_count saturation: held at max; no wrap.

Decomposition:
- Shared package holds:
  - op encodings OP_NOP/OP_SPIKE/OP_REWARD/OP_END;
  - state encoding;
  - packet field bit positions;
  - DEPTH/ADDR_W/DATA_W constants shared with the memory block.
- One sub-module: packet_decoder. It is combinational: mem_packet in; is_event, is_end, neuron, weight, reward out.
- The sequencer FSM, pointer and counter stay in packet_sequencer.

Test Plan:
- Linear run: mem = {0x5A, 0x00, 0x93, 0xC0, ...}, loop_en=0, evt_ready=1, start.
  - Required: event 1 is neuron 1, weight 0xA, reward 0.
  - Required: event 2 is neuron 1, weight 3, reward 1.
  - Required: END at addr 3, then done; evt_count=2; first evt_valid exactly 2 cycles after start.
- Backpressure: single SPIKE 0x47 at addr 0, evt_ready=0 for 5 cycles then 1.
  - Required: evt_valid held 6 cycles with fields stable; evt_count=1 after acceptance.
- All-NOP wrap: all entries 0x00.
  - loop_en=0: done 16 cycles after FETCH entry; evt_count=0.
  - loop_en=1: mem_addr wraps 15→0; busy stays high until stop.
  - Required: no done pulse on stop.
- Write stall: assert mem_write_mode during FETCH at addr 2 for 3 cycles.
  - Required: mem_addr stays 2 with no event.
  - Required: after release, the packet then present at addr 2 is decoded.
- Abort and reset: stop during EMIT → evt_valid drops next cycle, state IDLE. Then rst_n low mid-run → all outputs at reset values immediately, asynchronously.
- Saturation: 16 SPIKE entries, loop_en=1, evt_ready=1, run 300 events. Required: evt_count sticks at 255.

Source files
------------

// File: rtl/packet_sequencer_pkg.sv
// Shared constants, packet field layout and encodings for the packet memory
// and its downstream sequencer.
package packet_sequencer_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam int unsigned NEURON_W = 2;
  localparam int unsigned WEIGHT_W = 4;

  // Packet layout: [7:6] op, [5:4] neuron, [3:0] weight
  localparam int unsigned OP_HI     = 7;
  localparam int unsigned OP_LO     = 6;
  localparam int unsigned NEURON_HI = 5;
  localparam int unsigned NEURON_LO = 4;
  localparam int unsigned WEIGHT_HI = 3;
  localparam int unsigned WEIGHT_LO = 0;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_SPIKE  = 2'b01,
    OP_REWARD = 2'b10,
    OP_END    = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EMIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/packet_sequencer_decoder.sv
// Combinational decode of one 8-bit packet into event/end flags and fields.
module packet_decoder
  import packet_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0]   packet,
  output logic                is_event,
  output logic                is_end,
  output logic [NEURON_W-1:0] neuron,
  output logic [WEIGHT_W-1:0] weight,
  output logic                reward
);

  op_t op;

  assign op       = op_t'(packet[OP_HI:OP_LO]);
  assign is_event = (op == OP_SPIKE) || (op == OP_REWARD);
  assign is_end   = (op == OP_END);
  assign neuron   = packet[NEURON_HI:NEURON_LO];
  assign weight   = packet[WEIGHT_HI:WEIGHT_LO];
  // Upper op bit distinguishes REWARD from SPIKE
  assign reward   = packet[OP_HI];

endmodule

// File: rtl/packet_sequencer.sv
// Walks the packet memory from address 0 and emits decoded spike/reward
// events over a valid/ready handshake.
module packet_sequencer
  import packet_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                mem_write_mode,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_packet,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [NEURON_W-1:0] evt_neuron,
  output logic [WEIGHT_W-1:0] evt_weight,
  output logic                evt_reward,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    evt_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t state;

  logic                dec_event;
  logic                dec_end;
  logic [NEURON_W-1:0] dec_neuron;
  logic [WEIGHT_W-1:0] dec_weight;
  logic                dec_reward;

  logic                at_last;
  logic                run_over;
  logic [ADDR_W-1:0]   next_addr;

  packet_decoder u_decoder (
    .packet   (mem_packet),
    .is_event (dec_event),
    .is_end   (dec_end),
    .neuron   (dec_neuron),
    .weight   (dec_weight),
    .reward   (dec_reward)
  );

  // Pointer advance: wrap to 0 when looping, otherwise the run ends at the last entry
  assign at_last   = (mem_addr == LAST_ADDR);
  assign run_over  = at_last && !loop_en;
  assign next_addr = at_last ? '0 : mem_addr + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_addr   <= '0;
      evt_valid  <= 1'b0;
      evt_neuron <= '0;
      evt_weight <= '0;
      evt_reward <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      evt_count  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort holds pointer and count; any pending event is dropped
        state     <= ST_IDLE;
        evt_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              mem_addr  <= '0;
              evt_count <= '0;
              busy      <= 1'b1;
              state     <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (!mem_write_mode) begin
              if (dec_end) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else if (dec_event) begin
                evt_neuron <= dec_neuron;
                evt_weight <= dec_weight;
                evt_reward <= dec_reward;
                evt_valid  <= 1'b1;
                state      <= ST_EMIT;
              end else if (run_over) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                mem_addr <= next_addr;
              end
            end
          end
          ST_EMIT: begin
            if (evt_ready) begin
              evt_valid <= 1'b0;
              if (evt_count != CNT_MAX) begin
                evt_count <= evt_count + CNT_W'(1);
              end
              if (run_over) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                mem_addr <= next_addr;
                state    <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_sequencer.sv
// Self-checking bench for packet_sequencer: table-driven single-packet runs
// plus hand-written multi-cycle sequences, with an event scoreboard.
module tb_packet_sequencer;
  import packet_sequencer_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic       mem_write_mode;
  logic [3:0] mem_addr;
  logic [7:0] mem_packet;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_neuron;
  logic [3:0] evt_weight;
  logic       evt_reward;
  logic       busy;
  logic       done;
  logic [7:0] evt_count;

  logic [7:0] mem [16];
  assign mem_packet = mem[mem_addr];

  typedef struct {
    logic [1:0] neuron;
    logic [3:0] weight;
    logic       reward;
  } ev_t;

  typedef struct {
    logic [7:0] pkt;
    logic       is_ev;
    logic [1:0] neuron;
    logic [3:0] weight;
    logic       reward;
    logic [3:0] end_addr;
  } vec_t;

  ev_t  sb_q[$];
  vec_t vecs[7];
  int   total;
  int   bad;
  int   hs_cnt;

  packet_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .loop_en        (loop_en),
    .mem_write_mode (mem_write_mode),
    .mem_addr       (mem_addr),
    .mem_packet     (mem_packet),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_neuron     (evt_neuron),
    .evt_weight     (evt_weight),
    .evt_reward     (evt_reward),
    .busy           (busy),
    .done           (done),
    .evt_count      (evt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void sb_pop();
    ev_t e;
    hs_cnt++;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_event", 32'({evt_neuron, evt_weight, evt_reward}), 32'hFFFF_FFFF);
    end else begin
      e = sb_q.pop_front();
      check("sb_event", 32'({evt_neuron, evt_weight, evt_reward}), 32'({e.neuron, e.weight, e.reward}));
    end
  endfunction

  function automatic void push_ev(input logic [1:0] n, input logic [3:0] w, input logic r);
    ev_t e;
    e.neuron = n;
    e.weight = w;
    e.reward = r;
    sb_q.push_back(e);
  endfunction

  // Reference walk of the memory: queue the events a run should accept
  function automatic void model_push(input int max_ev, input bit lp);
    int a;
    int n;
    logic [7:0] p;
    logic [1:0] op;
    a = 0;
    n = 0;
    for (int it = 0; it < 5000 && n < max_ev; it++) begin
      p  = mem[a];
      op = p[7:6];
      if (op == 2'b11) break;
      if (op == 2'b01 || op == 2'b10) begin
        push_ev(p[5:4], p[3:0], op == 2'b10);
        n++;
      end
      if (a == 15) begin
        if (lp) a = 0;
        else break;
      end else begin
        a++;
      end
    end
  endfunction

  function automatic void clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endfunction

  // One clock: handshakes are scored at the falling edge, then settle past the rising edge
  task automatic step();
    @(negedge clk);
    if (rst_n && evt_valid && evt_ready) sb_pop();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      step();
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int c;
    int base;
    int prev;
    bit wrapped;
    bit busy_ok;
    bit seen;
    logic [3:0] addr_before;

    total = 0;
    bad = 0;
    hs_cnt = 0;
    rst_n = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    mem_write_mode = 1'b0;
    evt_ready = 1'b1;
    clear_mem();

    vecs[0] = '{8'h5A, 1'b1, 2'd1, 4'hA, 1'b0, 4'd1};
    vecs[1] = '{8'h93, 1'b1, 2'd1, 4'h3, 1'b1, 4'd1};
    vecs[2] = '{8'h47, 1'b1, 2'd0, 4'h7, 1'b0, 4'd1};
    vecs[3] = '{8'hBF, 1'b1, 2'd3, 4'hF, 1'b1, 4'd1};
    vecs[4] = '{8'h6C, 1'b1, 2'd2, 4'hC, 1'b0, 4'd1};
    vecs[5] = '{8'h00, 1'b0, 2'd0, 4'h0, 1'b0, 4'd1};
    vecs[6] = '{8'hC5, 1'b0, 2'd0, 4'h0, 1'b0, 4'd0};

    // Reset state
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_evt_count", 32'(evt_count), 0);
    check("rst_fields", 32'({evt_neuron, evt_weight, evt_reward}), 0);
    rst_n = 1'b1;
    step();

    // Linear run with latency check
    clear_mem();
    mem[0] = 8'h5A; mem[1] = 8'h00; mem[2] = 8'h93; mem[3] = 8'hC0;
    model_push(100, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("lin_valid_cycle1", 32'(evt_valid), 0);
    step();
    check("lin_valid_cycle2", 32'(evt_valid), 1);
    wait_done(40, c);
    check("lin_count", 32'(evt_count), 2);
    check("lin_end_addr", 32'(mem_addr), 3);
    step();
    check("lin_done_pulse", 32'(done), 0);
    check("lin_busy_idle", 32'(busy), 0);
    check("lin_sb_empty", 32'(sb_q.size()), 0);

    // Table of single-packet runs followed by END
    for (int i = 0; i < 7; i++) begin
      clear_mem();
      mem[0] = vecs[i].pkt;
      mem[1] = 8'hC0;
      if (vecs[i].is_ev) push_ev(vecs[i].neuron, vecs[i].weight, vecs[i].reward);
      start_run();
      wait_done(20, c);
      check("vec_count", 32'(evt_count), 32'(vecs[i].is_ev));
      check("vec_end_addr", 32'(mem_addr), 32'(vecs[i].end_addr));
      step();
      check("vec_sb_empty", 32'(sb_q.size()), 0);
    end

    // Backpressure: fields stay stable while ready is low
    clear_mem();
    mem[0] = 8'h47; mem[1] = 8'hC0;
    evt_ready = 1'b0;
    push_ev(2'd0, 4'h7, 1'b0);
    start_run();
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_held", 32'(evt_valid), 1);
      check("bp_fields", 32'({evt_neuron, evt_weight, evt_reward}), 32'({2'd0, 4'h7, 1'b0}));
      step();
    end
    check("bp_valid_6th", 32'(evt_valid), 1);
    evt_ready = 1'b1;
    step();
    check("bp_valid_drop", 32'(evt_valid), 0);
    check("bp_count", 32'(evt_count), 1);
    wait_done(20, c);
    step();
    check("bp_sb_empty", 32'(sb_q.size()), 0);

    // All-NOP, no loop: done 16 cycles after FETCH entry
    clear_mem();
    loop_en = 1'b0;
    start_run();
    wait_done(40, c);
    check("nop_cycles", 32'(c), 16);
    check("nop_count", 32'(evt_count), 0);
    check("nop_busy_at_done", 32'(busy), 0);
    step();

    // All-NOP with loop: wraps and stays busy until stop, no done pulse
    loop_en = 1'b1;
    start_run();
    wrapped = 1'b0;
    busy_ok = 1'b1;
    prev = 32'(mem_addr);
    for (int k = 0; k < 40; k++) begin
      step();
      if (prev == 15 && mem_addr == 4'd0) wrapped = 1'b1;
      if (!busy) busy_ok = 1'b0;
      prev = 32'(mem_addr);
    end
    check("loop_wrapped", 32'(wrapped), 1);
    check("loop_busy", 32'(busy_ok), 1);
    addr_before = mem_addr;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 0);
    check("loop_stop_addr_held", 32'(mem_addr), 32'(addr_before));
    seen = done;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | done;
    end
    check("loop_stop_no_done", 32'(seen), 0);
    loop_en = 1'b0;

    // Write stall at address 2; packet rewritten during the stall is decoded
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h21; mem[3] = 8'hC0;
    start_run();
    step();
    step();
    check("stall_at_addr2", 32'(mem_addr), 2);
    mem_write_mode = 1'b1;
    mem[2] = 8'h6C;
    push_ev(2'd2, 4'hC, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr", 32'(mem_addr), 2);
      check("stall_no_event", 32'(evt_valid), 0);
    end
    mem_write_mode = 1'b0;
    step();
    check("stall_release_valid", 32'(evt_valid), 1);
    check("stall_release_fields", 32'({evt_neuron, evt_weight, evt_reward}), 32'({2'd2, 4'hC, 1'b0}));
    wait_done(20, c);
    check("stall_count", 32'(evt_count), 1);
    step();
    check("stall_sb_empty", 32'(sb_q.size()), 0);

    // Stop during EMIT
    clear_mem();
    mem[0] = 8'h47; mem[1] = 8'hC0;
    evt_ready = 1'b0;
    start_run();
    step();
    check("abort_emit_valid", 32'(evt_valid), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_valid", 32'(evt_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_count", 32'(evt_count), 0);
    check("abort_addr", 32'(mem_addr), 0);
    step();
    check("abort_idle_busy", 32'(busy), 0);
    check("abort_idle_done", 32'(done), 0);

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_busy", 32'(busy), 0);
    step();
    check("start_stop_busy2", 32'(busy), 0);

    // Asynchronous reset while an event is pending
    clear_mem();
    mem[2] = 8'h47; mem[3] = 8'hC0;
    start_run();
    step();
    step();
    step();
    check("areset_pre_valid", 32'(evt_valid), 1);
    check("areset_pre_addr", 32'(mem_addr), 2);
    #1 rst_n = 1'b0;
    #1;
    check("areset_addr", 32'(mem_addr), 0);
    check("areset_valid", 32'(evt_valid), 0);
    check("areset_busy", 32'(busy), 0);
    check("areset_fields", 32'({evt_neuron, evt_weight, evt_reward}), 0);
    check("areset_count", 32'(evt_count), 0);
    check("areset_done", 32'(done), 0);
    step();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    step();

    // Saturation: 300 accepted events, counter sticks at 255
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = {2'b01, 2'(i), 4'(i)};
    loop_en = 1'b1;
    model_push(300, 1'b1);
    base = hs_cnt;
    start_run();
    c = 0;
    while ((hs_cnt - base) < 300 && c < 1000) begin
      step();
      c++;
    end
    check("sat_events", 32'(hs_cnt - base), 300);
    check("sat_count", 32'(evt_count), 255);
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    check("sat_count_held", 32'(evt_count), 255);
    check("sat_sb_empty", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
